// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 5-stage RV32I pipeline.
// Drives a req/ack data-memory bus with byte lanes, extracts and extends load
// data, stalls the upstream stages while an access is outstanding, and builds
// the MEM/WB register. A misaligned access or a bus timeout turns the
// offending instruction into a bubble and raises a one-cycle error pulse.
module mem_stage_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    // EX/MEM register fields
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic [1:0]        exm_reg_wb_src,
    input  logic              exm_mem_read,
    input  logic              exm_mem_write,
    input  logic [31:0]       exm_pc_plus_4,
    input  logic [31:0]       exm_alu_result,
    input  logic [31:0]       exm_rd2,
    input  logic [4:0]        exm_rd,
    input  logic [2:0]        exm_funct3,
    input  logic [31:0]       exm_instr,
    // data-memory bus
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    // pipeline control and error pulses
    output logic              stall,
    output logic              misalign_err,
    output logic              bus_err,
    // MEM/WB register
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [1:0]        wb_reg_wb_src,
    output logic [31:0]       wb_pc_plus_4,
    output logic [31:0]       wb_alu_result,
    output logic [31:0]       wb_mem_read_data,
    output logic [31:0]       wb_instr,
    output logic [4:0]        wb_rd
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    logic        is_store;
    logic        is_load;
    logic        mem_op;
    logic        aligned;
    logic        in_wait;
    logic        timed_out;
    logic        req_int;
    logic        complete;
    logic        wb_load;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    // Decode the access: store wins when both read and write are flagged.
    always_comb begin
        is_store = exm_mem_write;
        is_load  = exm_mem_read & ~exm_mem_write;
        mem_op   = exm_valid & (exm_mem_read | exm_mem_write);
        aligned  = 1'b0;
        case (exm_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~exm_alu_result[0];
            2'b10:   aligned = (exm_alu_result[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data by access size.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = exm_rd2;
        case (exm_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << exm_alu_result[1:0];
                wdata_calc = {4{exm_rd2[7:0]}};
            end
            2'b01: begin
                be_calc    = exm_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{exm_rd2[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = exm_rd2;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        lane_byte = dmem_rdata[7:0];
        case (exm_alu_result[1:0])
            2'b00:   lane_byte = dmem_rdata[7:0];
            2'b01:   lane_byte = dmem_rdata[15:8];
            2'b10:   lane_byte = dmem_rdata[23:16];
            default: lane_byte = dmem_rdata[31:24];
        endcase
        lane_half = exm_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (exm_funct3)
            3'd0:    load_data = {{24{lane_byte[7]}}, lane_byte};
            3'd1:    load_data = {{16{lane_half[15]}}, lane_half};
            3'd4:    load_data = {24'd0, lane_byte};
            3'd5:    load_data = {16'd0, lane_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Bus request and stall. The timeout cycle drops the request, so an ack
    // arriving then is ignored. Reset kills the request immediately.
    always_comb begin
        in_wait   = (state == WAIT);
        timed_out = in_wait && (count == CNT_MAX);
        req_int   = ~reset & ((~in_wait & mem_op & aligned) | (in_wait & ~timed_out));
        complete  = req_int & dmem_ack;
        wb_load   = complete | (~reset & ~in_wait & ~mem_op);

        dmem_req   = req_int;
        dmem_we    = req_int & is_store;
        dmem_addr  = req_int ? {exm_alu_result[ADDR_W-1:2], 2'b00} : '0;
        dmem_be    = req_int ? be_calc : 4'b0000;
        dmem_wdata = (req_int & is_store) ? wdata_calc : 32'd0;
        stall      = req_int & ~dmem_ack;
    end

    // Access FSM: tracks the outstanding request, its timeout and the error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && aligned && !dmem_ack) begin
                        state <= WAIT;
                        count <= CNT_W'(1);
                    end else if (mem_op && !aligned) begin
                        misalign_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (complete) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (timed_out) begin
                        state   <= IDLE;
                        count   <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // MEM/WB register: load on completion or passthrough, otherwise a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid         <= 1'b0;
            wb_reg_write     <= 1'b0;
            wb_reg_wb_src    <= 2'd0;
            wb_pc_plus_4     <= 32'd0;
            wb_alu_result    <= 32'd0;
            wb_mem_read_data <= 32'd0;
            wb_instr         <= 32'd0;
            wb_rd            <= 5'd0;
        end else if (wb_load) begin
            wb_valid         <= exm_valid;
            wb_reg_write     <= exm_reg_write;
            wb_reg_wb_src    <= exm_reg_wb_src;
            wb_pc_plus_4     <= exm_pc_plus_4;
            wb_alu_result    <= exm_alu_result;
            wb_mem_read_data <= (complete && is_load) ? load_data : 32'd0;
            wb_instr         <= exm_instr;
            wb_rd            <= exm_rd;
        end else begin
            wb_valid         <= 1'b0;
            wb_reg_write     <= 1'b0;
            wb_reg_wb_src    <= 2'd0;
            wb_pc_plus_4     <= 32'd0;
            wb_alu_result    <= 32'd0;
            wb_mem_read_data <= 32'd0;
            wb_instr         <= 32'd0;
            wb_rd            <= 5'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases followed by random
// transactions, each checked cycle by cycle against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int T = 16;

    logic        clk;
    logic        reset;
    logic        exm_valid, exm_reg_write, exm_mem_read, exm_mem_write;
    logic [1:0]  exm_reg_wb_src;
    logic [31:0] exm_pc_plus_4, exm_alu_result, exm_rd2, exm_instr;
    logic [4:0]  exm_rd;
    logic [2:0]  exm_funct3;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall, misalign_err, bus_err;
    logic        wb_valid, wb_reg_write;
    logic [1:0]  wb_reg_wb_src;
    logic [31:0] wb_pc_plus_4, wb_alu_result, wb_mem_read_data, wb_instr;
    logic [4:0]  wb_rd;

    int tests = 0;
    int fails = 0;

    mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write),
        .exm_reg_wb_src(exm_reg_wb_src), .exm_mem_read(exm_mem_read),
        .exm_mem_write(exm_mem_write), .exm_pc_plus_4(exm_pc_plus_4),
        .exm_alu_result(exm_alu_result), .exm_rd2(exm_rd2), .exm_rd(exm_rd),
        .exm_funct3(exm_funct3), .exm_instr(exm_instr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .misalign_err(misalign_err),
        .bus_err(bus_err), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_reg_wb_src(wb_reg_wb_src), .wb_pc_plus_4(wb_pc_plus_4),
        .wb_alu_result(wb_alu_result), .wb_mem_read_data(wb_mem_read_data),
        .wb_instr(wb_instr), .wb_rd(wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rules written as plain arithmetic on byte offsets.
    function automatic bit ref_aligned(input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (f3[1:0] == 2'd3) return 1'b0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int off = a % 4;
        if (f3[1:0] == 2'd0) return 4'(1 << off);
        if (f3[1:0] == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return (d % 256) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) % 256;
        h = (w >> (8 * ((a % 4) / 2 * 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? (b - 256) : b;
            3'd1:    return (h >= 32768) ? (h - 65536) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Run one EX/MEM entry to completion. Called at posedge+1.
    // dly = cycle (0 = first) on which ack arrives; negative = never.
    task automatic do_txn(input logic v, input logic rd_f, input logic wr_f,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd2, input logic [31:0] rdata,
                          input int dly, input logic rw, input logic [4:0] rd);
        bit          am, mo, done, ack_now, exp_req, tmo;
        logic [31:0] pc, ins;
        logic [1:0]  src;
        int          k;
        pc  = $urandom;
        ins = $urandom;
        src = 2'($urandom_range(0, 3));
        exm_valid = v; exm_mem_read = rd_f; exm_mem_write = wr_f;
        exm_funct3 = f3; exm_alu_result = addr; exm_rd2 = rd2;
        exm_reg_write = rw; exm_rd = rd; exm_pc_plus_4 = pc;
        exm_instr = ins; exm_reg_wb_src = src;
        mo  = v && (rd_f || wr_f);
        am  = mo && ref_aligned(f3, addr);
        tmo = 1'b0;
        k   = 0;
        done = 1'b0;
        while (!done && k <= T + 2) begin
            if (am) ack_now = (k == dly) || (dly < 0 && k == T && $urandom_range(0, 1) == 1);
            else    ack_now = 1'($urandom_range(0, 1));
            dmem_ack   = ack_now;
            dmem_rdata = (am && k == dly) ? rdata : $urandom;
            #3;
            exp_req = am && !(dly < 0 && k == T);
            check_val("dmem_req", 32'(dmem_req), 32'(exp_req));
            check_val("stall", 32'(stall), 32'(exp_req && !ack_now));
            if (exp_req) begin
                check_val("dmem_addr", dmem_addr, addr - (addr % 4));
                check_val("dmem_be", 32'(dmem_be), 32'(ref_be(f3, addr)));
                check_val("dmem_we", 32'(dmem_we), 32'(wr_f));
                if (wr_f) check_val("dmem_wdata", dmem_wdata, ref_wdata(f3, rd2));
            end
            @(posedge clk);
            #1;
            tmo  = am && dly < 0 && k == T;
            done = !am || (k == dly) || tmo;
            check_val("misalign_err", 32'(misalign_err), 32'(done && mo && !am));
            check_val("bus_err", 32'(bus_err), 32'(tmo));
            if (done && !(mo && !am) && !tmo) begin
                check_val("wb_valid", 32'(wb_valid), 32'(v));
                check_val("wb_reg_write", 32'(wb_reg_write), 32'(rw));
                check_val("wb_alu_result", wb_alu_result, addr);
                check_val("wb_rd", 32'(wb_rd), 32'(rd));
                check_val("wb_pc_plus_4", wb_pc_plus_4, pc);
                check_val("wb_instr", wb_instr, ins);
                check_val("wb_src", 32'(wb_reg_wb_src), 32'(src));
                check_val("wb_read_data", wb_mem_read_data,
                          (am && rd_f && !wr_f) ? ref_load(f3, addr, rdata) : 32'd0);
            end else begin
                check_val("bubble_valid", 32'(wb_valid), 32'd0);
                check_val("bubble_regw", 32'(wb_reg_write), 32'd0);
                check_val("bubble_alu", wb_alu_result, 32'd0);
                check_val("bubble_data", wb_mem_read_data, 32'd0);
            end
            k++;
        end
        if (!done) check_val("txn_bound", 32'd0, 32'd1);
        dmem_ack = 1'b0;
        $display("[TB] txn v=%0b rd=%0b wr=%0b f3=%0d addr=%h dly=%0d cycles=%0d",
                 v, rd_f, wr_f, f3, addr, dly, k);
    endtask

    initial begin
        reset = 1'b1;
        exm_valid = 0; exm_reg_write = 0; exm_mem_read = 0; exm_mem_write = 0;
        exm_reg_wb_src = 0; exm_pc_plus_4 = 0; exm_alu_result = 0; exm_rd2 = 0;
        exm_rd = 0; exm_funct3 = 0; exm_instr = 0; dmem_rdata = 0; dmem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_val("rst_req", 32'(dmem_req), 32'd0);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
        reset = 1'b0;

        // Directed cases from the feature list.
        do_txn(1, 0, 0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 1, 5'd5);
        do_txn(1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, 5'd6);
        do_txn(1, 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, 5'd7);
        do_txn(1, 0, 1, 3'd1, 32'h202, 32'hABCD_1234, 32'h0, 3, 0, 5'd0);
        do_txn(1, 1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1, 5'd8);
        do_txn(1, 1, 0, 3'd2, 32'h400, 32'h0, 32'h0, -1, 1, 5'd9);
        do_txn(1, 1, 1, 3'd2, 32'h404, 32'h5555_AAAA, 32'h1, T - 1, 1, 5'd10);

        // Reset while an access is outstanding.
        exm_valid = 1; exm_mem_read = 1; exm_mem_write = 0; exm_funct3 = 3'd2;
        exm_alu_result = 32'h800; dmem_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("pre_rst_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        check_val("midrst_req", 32'(dmem_req), 32'd0);
        check_val("midrst_stall", 32'(stall), 32'd0);
        check_val("midrst_wb", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_txn(1, 0, 0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 1, 5'd5);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            int       kind, dly;
            logic     v, r, w;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            v = ($urandom_range(0, 9) != 0);
            r = (kind >= 3 && kind <= 6) || kind == 9;
            w = (kind >= 7);
            if (w) f3 = 3'($urandom_range(0, 3));
            else begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2;
                    3: f3 = 3'd4; 4: f3 = 3'd5; default: f3 = 3'd3;
                endcase
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            case ($urandom_range(0, 19))
                0:       dly = -1;
                1, 2:    dly = $urandom_range(6, T - 1);
                default: dly = $urandom_range(0, 5);
            endcase
            do_txn(v, r, w, f3, a, $urandom, $urandom, dly, 1'($urandom), 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the design wedges the bench.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM register fields and drives a req/ack data-memory bus with byte lanes.
- Performs load extraction with sign/zero extension, stalls upstream stages while an access is outstanding, and produces the MEM/WB register.
- Detects misaligned accesses and bus timeouts, and converts the offending instruction into a bubble.

Parameters:
ADDR_W, 32, data-memory byte-address width
TIMEOUT_CYCLES, 16, max cycles waiting for dmem_ack before abort (>=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
exm_valid  in  1  EX/MEM entry holds a real instruction
exm_reg_write  in  1  writeback enable
exm_reg_wb_src  in  2  writeback source select (passed through)
exm_mem_read  in  1  load
exm_mem_write  in  1  store
exm_pc_plus_4  in  32  passed through
exm_alu_result  in  32  effective address / ALU value
exm_rd2  in  32  store data
exm_rd  in  5  destination register
exm_funct3  in  3  access size/sign
exm_instr  in  32  testbench trace instruction
dmem_req  out  1  access request
dmem_we  out  1  1=store
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read word, valid with dmem_ack
dmem_ack  in  1  access complete this cycle
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
misalign_err  out  1  one-cycle pulse, misaligned access dropped
bus_err  out  1  one-cycle pulse, access timed out
wb_valid, wb_reg_write  out  1 each  MEM/WB register
wb_reg_wb_src  out  2  MEM/WB
wb_pc_plus_4, wb_alu_result, wb_mem_read_data, wb_instr  out  32 each  MEM/WB
wb_rd  out  5  MEM/WB

Behaviour:
- Reset (async): FSM=IDLE, timeout counter=0, all outputs 0.
- mem_op = exm_valid & (exm_mem_read | exm_mem_write).
  - Store takes priority if both are set.
- Alignment, by addr = exm_alu_result:
  - funct3[1:0]=00 (byte): always aligned.
  - 01 (half): aligned if addr[0]=0.
  - 10 (word): aligned if addr[1:0]=0.
  - 11: treated as misaligned.
- dmem_be:
  - Byte: 1<<addr[1:0].
  - Half: 0011 or 1100 by addr[1].
  - Word: 1111.
- dmem_wdata:
  - SB: {4{rd2[7:0]}}.
  - SH: {2{rd2[15:0]}}.
  - SW: rd2.
- Load extract: select lane by addr[1:0].
  - funct3 0 LB: sign-extend.
  - 1 LH: sign-extend.
  - 2 LW: full word.
  - 4 LBU: zero-extend.
  - 5 LHU: zero-extend.
- FSM IDLE:
  - mem_op & aligned: dmem_req=1 combinationally with addr/be/we/wdata.
    - dmem_ack same cycle: zero-wait completion, stay IDLE, stall=0.
    - Else: go WAIT, counter=1, stall=1.
  - mem_op & misaligned: no request; misalign_err pulses next cycle; MEM/WB loads a bubble.
  - Non-memory op or invalid: 1-cycle passthrough to MEM/WB.
- FSM WAIT:
  - dmem_req held with identical signals.
  - Upstream holds exm_* stable while stall=1.
  - stall = ~dmem_ack.
  - dmem_ack: capture result, go IDLE.
  - Else, counter==TIMEOUT_CYCLES: drop request, bus_err pulses next cycle, MEM/WB bubble, go IDLE, stall=0 that cycle.
  - Otherwise counter++.
- MEM/WB update, every edge:
  - Completed access or passthrough: load fields; wb_mem_read_data = extracted load data, else 0.
  - Stall cycle, misalign, or timeout: bubble (wb_valid=0, wb_reg_write=0, other fields 0).
- dmem_ack while dmem_req=0: ignored.
- Reset mid-WAIT: request drops immediately; no writeback.

Test Plan:
- ALU op, exm_alu_result=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5, no req, stall=0.
- LB addr=0x103, ack same cycle, rdata=0x80FF_0000 -> dmem_addr=0x100, be=1000, wb_mem_read_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr=0x202, rd2=0xABCD_1234, ack after 3 cycles -> stall=1 for 3 cycles, 3 bubbles in MEM/WB, be=1100, wdata=0x1234_1234, then wb_valid=1, stall=0.
- LW addr=0x101 -> no dmem_req, misalign_err pulse, wb_valid=0, wb_reg_write=0.
- LW, ack never asserted, TIMEOUT_CYCLES=16 -> stall high 16 cycles, req drops, bus_err pulse, bubble, pipeline resumes.
- Reset asserted in WAIT -> dmem_req, stall, and all wb_* go 0 asynchronously; post-reset ALU op passes normally.
